// File: rtl/mem_bank_arb_pkg.sv
// Shared types, widths and helpers for the banked-memory port arbiter.
package mem_bank_arb_pkg;

    // Width of each per-port grant counter.
    localparam int unsigned GntCntWidth = 32;

    // Arbiter lock state: free to re-arbitrate, or pinned to a stalled port.
    typedef enum logic {
        ArbFree   = 1'b0,
        ArbLocked = 1'b1
    } arb_state_e;

    // Index width that stays legal (>= 1 bit) even for a single entry.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [GntCntWidth-1:0] sat_inc(input logic [GntCntWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO holding the issuing port index of each outstanding
// transaction. usage_o reports the fill level 0..DEPTH, full_o blocks issue.
module fifo_v3
    import mem_bank_arb_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 1,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         push_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    input  logic                         pop_i
);

    localparam int unsigned PtrW   = idx_width(DEPTH);
    localparam int unsigned UsageW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [UsageW-1:0]     cnt_q, cnt_d;
    logic                  empty;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (cnt_q == '0);
    assign full_o  = (cnt_q == UsageW'(DEPTH));
    assign usage_o = cnt_q;

    // Pointer/count next-state and read data, with optional bypass when empty.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty;
        data_o   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;

        if (FALL_THROUGH && empty && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                do_push = 1'b0;
                do_pop  = 1'b0;
            end
        end

        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and fill-level registers; flush behaves like reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst_ni || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; the count and pointers alone decide which entries are valid.
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mem_bank_port_arbiter.sv
// Round-robin arbiter sharing one banked-memory request port among NumPorts
// requesters, with stall lock, outstanding limit and in-order response routing.
// Optional per-port grant counters: define MEM_BANK_ARB_GNT_CNT_EN.
module mem_bank_port_arbiter
    import mem_bank_arb_pkg::*;
#(
    parameter int unsigned NumPorts   = 2,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned WUserWidth = 1,
    parameter int unsigned RUserWidth = 1,
    parameter int unsigned NumBanks   = 1,
    parameter int unsigned MaxTrans   = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    // Requester side
    input  logic [NumPorts-1:0]                        req_i,
    output logic [NumPorts-1:0]                        gnt_o,
    input  logic [NumPorts-1:0][AddrWidth-1:0]         addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]         wdata_i,
    input  logic [NumPorts-1:0][DataWidth/8-1:0]       strb_i,
    input  logic [NumPorts-1:0][WUserWidth-1:0]        wuser_i,
    input  logic [NumPorts-1:0]                        we_i,
    output logic [NumPorts-1:0]                        rvalid_o,
    output logic [DataWidth-1:0]                       rdata_o,
    output logic [NumBanks*RUserWidth-1:0]             ruser_o,
    // Memory side
    output logic                                       req_o,
    input  logic                                       gnt_i,
    output logic [AddrWidth-1:0]                       addr_o,
    output logic [DataWidth-1:0]                       wdata_o,
    output logic [DataWidth/8-1:0]                     strb_o,
    output logic [WUserWidth-1:0]                      wuser_o,
    output logic                                       we_o,
    input  logic                                       rvalid_i,
    input  logic [DataWidth-1:0]                       rdata_i,
    input  logic [NumBanks*RUserWidth-1:0]             ruser_i,
    // Status
    output logic                                       err_o,
    output logic [NumPorts-1:0][GntCntWidth-1:0]       gnt_cnt_o
);

    localparam int unsigned IdxW = idx_width(NumPorts);
    localparam int unsigned OutW = $clog2(MaxTrans + 1);

    logic [IdxW-1:0] rr_q, rr_d;
    arb_state_e      lock_q, lock_d;
    logic [IdxW-1:0] sel_q, sel_d;
    logic            err_q, err_d;

    logic [IdxW-1:0] free_idx;
    logic [IdxW-1:0] cand;
    logic            cand_valid;
    logic            can_issue;
    logic            handshake;
    logic            route_full;
    logic            route_empty;
    logic            pop;
    logic [OutW-1:0] outstanding;
    logic [IdxW-1:0] route_head;

    // Round-robin scan: first requesting port at or after rr_q, wrapping.
    always_comb begin
        logic [IdxW-1:0] p;
        p        = '0;
        free_idx = '0;
        for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
            p = IdxW'((int'(rr_q) + i) % int'(NumPorts));
            if (req_i[p]) begin
                free_idx = p;
            end
        end
    end

    // Arbitration FSM: pick candidate, issue, lock on stall, advance pointer.
    always_comb begin
        lock_d = lock_q;
        sel_d  = sel_q;
        rr_d   = rr_q;
        gnt_o  = '0;

        cand       = (lock_q == ArbLocked) ? sel_q : free_idx;
        cand_valid = req_i[cand];
        can_issue  = ~route_full;
        req_o      = can_issue & cand_valid;
        handshake  = req_o & gnt_i;

        if (handshake) begin
            gnt_o[cand] = 1'b1;
            rr_d        = (cand == IdxW'(NumPorts - 1)) ? '0 : cand + 1'b1;
        end

        case (lock_q)
            ArbFree: begin
                if (req_o && !gnt_i) begin
                    lock_d = ArbLocked;
                    sel_d  = cand;
                end
            end
            ArbLocked: begin
                // A dropped request while locked is a protocol violation: release.
                if (handshake || !req_i[sel_q]) begin
                    lock_d = ArbFree;
                end
            end
            default: lock_d = ArbFree;
        endcase
    end

    // Selected payload follows the candidate port.
    assign addr_o  = addr_i[cand];
    assign wdata_o = wdata_i[cand];
    assign strb_o  = strb_i[cand];
    assign wuser_o = wuser_i[cand];
    assign we_o    = we_i[cand];

    // Response routing: pop the oldest issuing port and steer rvalid to it.
    always_comb begin
        route_empty = (outstanding == '0);
        pop         = rvalid_i & ~route_empty;
        err_d       = err_q | (rvalid_i & route_empty);
        rvalid_o    = '0;
        if (pop) begin
            rvalid_o[route_head] = 1'b1;
        end
    end

    assign rdata_o = rdata_i;
    assign ruser_o = ruser_i;
    assign err_o   = err_q;

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            lock_q <= ArbFree;
            sel_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            sel_q  <= sel_d;
            err_q  <= err_d;
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (IdxW),
        .DEPTH        (MaxTrans)
    ) i_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (route_full),
        .usage_o (outstanding),
        .data_i  (cand),
        .push_i  (handshake),
        .data_o  (route_head),
        .pop_i   (pop)
    );

`ifdef MEM_BANK_ARB_GNT_CNT_EN
    logic [NumPorts-1:0][GntCntWidth-1:0] gnt_cnt_q, gnt_cnt_d;

    // Saturating per-port grant counters.
    always_comb begin
        for (int p = 0; p < int'(NumPorts); p++) begin
            gnt_cnt_d[p] = gnt_o[p] ? sat_inc(gnt_cnt_q[p]) : gnt_cnt_q[p];
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gnt_cnt_q <= '0;
        end else begin
            gnt_cnt_q <= gnt_cnt_d;
        end
    end

    assign gnt_cnt_o = gnt_cnt_q;
`else
    assign gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_bank_port_arbiter.sv
// Scoreboard bench for mem_bank_port_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_mem_bank_port_arbiter;
    import mem_bank_arb_pkg::*;

    localparam int NP  = 3;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int WUW = 3;
    localparam int RUW = 2;
    localparam int NB  = 2;
    localparam int RW  = NB * RUW;
    localparam int MT  = 4;

`ifdef MEM_BANK_ARB_GNT_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]                    req_i = '0;
    logic [NP-1:0]                    gnt_o;
    logic [NP-1:0][AW-1:0]            addr_i = '0;
    logic [NP-1:0][DW-1:0]            wdata_i = '0;
    logic [NP-1:0][SW-1:0]            strb_i = '0;
    logic [NP-1:0][WUW-1:0]           wuser_i = '0;
    logic [NP-1:0]                    we_i = '0;
    logic [NP-1:0]                    rvalid_o;
    logic [DW-1:0]                    rdata_o;
    logic [RW-1:0]                    ruser_o;
    logic                             req_o;
    logic                             gnt_i = 1'b0;
    logic [AW-1:0]                    addr_o;
    logic [DW-1:0]                    wdata_o;
    logic [SW-1:0]                    strb_o;
    logic [WUW-1:0]                   wuser_o;
    logic                             we_o;
    logic                             rvalid_i = 1'b0;
    logic [DW-1:0]                    rdata_i = '0;
    logic [RW-1:0]                    ruser_i = '0;
    logic                             err_o;
    logic [NP-1:0][GntCntWidth-1:0]   gnt_cnt_o;

    mem_bank_port_arbiter #(
        .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .WUserWidth(WUW),
        .RUserWidth(RUW), .NumBanks(NB), .MaxTrans(MT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .wdata_i(wdata_i),
        .strb_i(strb_i), .wuser_i(wuser_i), .we_i(we_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .ruser_o(ruser_o),
        .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .wdata_o(wdata_o),
        .strb_o(strb_o), .wuser_o(wuser_o), .we_o(we_o),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .ruser_i(ruser_i),
        .err_o(err_o), .gnt_cnt_o(gnt_cnt_o)
    );

    typedef struct {
        logic                  exp_req;
        logic [NP-1:0]         exp_gnt;
        logic [AW-1:0]         exp_addr;
        logic [NP-1:0]         exp_rvalid;
        logic                  exp_err;
        logic [NP-1:0][31:0]   exp_cnt;
    } cyc_t;

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [WUW-1:0] wuser;
        logic          we;
    } gnt_t;

    typedef struct {
        int            port;
        logic [DW-1:0] rdata;
        logic [RW-1:0] ruser;
    } rsp_t;

    cyc_t cyc_q[$];
    gnt_t gnt_q[$];
    rsp_t rsp_q[$];

    // Reference model state, phrased directly in terms of the arbitration rules.
    int m_rr;
    bit m_locked;
    int m_lock_port;
    int m_route[$];
    bit m_err;
    int m_cnt[NP];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_locked = 0;
        m_lock_port = 0;
        m_route.delete();
        m_err = 0;
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    endtask

    // Drive one cycle of stimulus and push the model's expectations.
    task automatic step(input logic rst, input logic [NP-1:0] req, input logic gnt,
                        input logic rv, input logic [DW-1:0] rdata);
        cyc_t c;
        gnt_t g;
        rsp_t r;
        int   cand;
        bit   valid;
        bit   ereq;
        bit   hs;
        @(posedge clk);
        #1;
        rst_n    = rst;
        req_i    = req;
        gnt_i    = gnt;
        rvalid_i = rv;
        rdata_i  = rdata;
        ruser_i  = RW'($urandom);
        for (int p = 0; p < NP; p++) begin
            addr_i[p]  = AW'($urandom);
            wdata_i[p] = $urandom;
            strb_i[p]  = SW'($urandom);
            wuser_i[p] = WUW'($urandom);
            we_i[p]    = 1'($urandom);
        end

        cand  = 0;
        valid = 0;
        if (m_locked) begin
            cand  = m_lock_port;
            valid = req[cand];
        end else begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (m_rr + k) % NP;
                if (!valid && req[p]) begin
                    cand  = p;
                    valid = 1;
                end
            end
        end
        ereq = valid && (m_route.size() < MT);
        hs   = ereq && gnt;

        c.exp_req    = ereq;
        c.exp_gnt    = '0;
        if (hs) c.exp_gnt[cand] = 1'b1;
        c.exp_addr   = addr_i[cand];
        c.exp_err    = m_err;
        c.exp_rvalid = '0;
        for (int p = 0; p < NP; p++) c.exp_cnt[p] = CntEn ? 32'(m_cnt[p]) : 32'd0;

        if (rv) begin
            if (m_route.size() > 0) begin
                r.port  = m_route.pop_front();
                r.rdata = rdata;
                r.ruser = ruser_i;
                rsp_q.push_back(r);
                c.exp_rvalid[r.port] = 1'b1;
            end else begin
                m_err = 1;
            end
        end

        if (hs) begin
            g.port  = cand;
            g.addr  = addr_i[cand];
            g.wdata = wdata_i[cand];
            g.strb  = strb_i[cand];
            g.wuser = wuser_i[cand];
            g.we    = we_i[cand];
            gnt_q.push_back(g);
            m_route.push_back(cand);
            m_rr     = (cand + 1) % NP;
            m_locked = 0;
            m_cnt[cand]++;
        end else if (ereq && !gnt) begin
            m_locked    = 1;
            m_lock_port = cand;
        end else if (m_locked && !req[m_lock_port]) begin
            m_locked = 0;
        end

        if (!rst) model_reset();
        cyc_q.push_back(c);
    endtask

    // Monitor: compares DUT outputs against queued expectations each cycle.
    initial begin
        cyc_t          c;
        gnt_t          g;
        rsp_t          r;
        logic [NP-1:0] oh;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                check("req_o", req_o, c.exp_req);
                check("gnt_o", gnt_o, c.exp_gnt);
                if (c.exp_req) check("addr_o", addr_o, c.exp_addr);
                check("rvalid_o", rvalid_o, c.exp_rvalid);
                check("err_o", err_o, c.exp_err);
                check("gnt_cnt_o", gnt_cnt_o, c.exp_cnt);
            end
            if (gnt_o != '0) begin
                if (gnt_q.size() == 0) begin
                    check("gnt_unexpected", gnt_o, '0);
                end else begin
                    g  = gnt_q.pop_front();
                    oh = '0;
                    oh[g.port] = 1'b1;
                    check("gnt_port", gnt_o, oh);
                    check("gnt_payload", {addr_o, wdata_o, strb_o, wuser_o, we_o},
                          {g.addr, g.wdata, g.strb, g.wuser, g.we});
                end
            end
            if (rvalid_o != '0) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", rvalid_o, '0);
                end else begin
                    r  = rsp_q.pop_front();
                    oh = '0;
                    oh[r.port] = 1'b1;
                    check("rsp_port", rvalid_o, oh);
                    check("rsp_payload", {rdata_o, ruser_o}, {r.rdata, r.ruser});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NP-1:0] rq;
        logic [AW-1:0] a1;
        model_reset();

        // Reset state
        step(0, '0, 0, 0, '0);
        step(0, '0, 0, 0, '0);
        step(1, '0, 0, 0, '0);
        @(negedge clk);
        check("reset_outputs", {req_o, gnt_o, rvalid_o, err_o}, '0);
        check("reset_cnt", gnt_cnt_o, '0);

        // Round robin with all ports requesting
        for (int i = 0; i < 6; i++) begin
            step(1, 3'b111, 1, (i > 0), $urandom);
            @(negedge clk);
            check("rr_order", gnt_o, 3'b001 << (i % 3));
        end
        step(1, '0, 0, 1, $urandom);

        // Stall lock on port 1 while port 0 joins
        step(1, 3'b010, 0, 0, '0);
        @(negedge clk);
        a1 = addr_i[1];
        check("lock_c1_addr", addr_o, a1);
        check("lock_c1_req", req_o, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(1, 3'b011, 0, 0, '0);
            @(negedge clk);
            a1 = addr_i[1];
            check("lock_hold_addr", addr_o, a1);
            check("lock_hold_gnt", gnt_o, '0);
        end
        step(1, 3'b011, 1, 0, '0);
        @(negedge clk);
        check("lock_grant_p1", gnt_o, 3'b010);
        step(1, 3'b001, 1, 0, '0);
        @(negedge clk);
        check("lock_then_p0", gnt_o, 3'b001);
        step(1, '0, 0, 1, $urandom);
        step(1, '0, 0, 1, $urandom);

        // Outstanding limit and full boundary
        for (int i = 0; i < MT; i++) begin
            step(1, 3'b001, 1, 0, '0);
            @(negedge clk);
            check("fill_gnt", gnt_o, 3'b001);
        end
        step(1, 3'b001, 1, 0, '0);
        @(negedge clk);
        check("full_blocked", {req_o, gnt_o}, '0);
        step(1, 3'b001, 1, 1, $urandom);
        @(negedge clk);
        check("full_rv_blocked", {req_o, gnt_o}, '0);
        check("full_rv_route", rvalid_o, 3'b001);
        step(1, 3'b001, 1, 0, '0);
        @(negedge clk);
        check("full_next_gnt", gnt_o, 3'b001);
        for (int i = 0; i < MT; i++) step(1, '0, 0, 1, $urandom);

        // In-order routing 2,0,2
        step(1, 3'b100, 1, 0, '0);
        step(1, 3'b001, 1, 0, '0);
        step(1, 3'b100, 1, 0, '0);
        step(1, '0, 0, 1, 32'hA);
        @(negedge clk);
        check("route_a", {rvalid_o, rdata_o}, {3'b100, 32'hA});
        step(1, '0, 0, 1, 32'hB);
        @(negedge clk);
        check("route_b", {rvalid_o, rdata_o}, {3'b001, 32'hB});
        step(1, '0, 0, 1, 32'hC);
        @(negedge clk);
        check("route_c", {rvalid_o, rdata_o}, {3'b100, 32'hC});

        // Grant counters after 5 grants to port 1
        step(0, '0, 0, 0, '0);
        step(1, '0, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(1, 3'b010, 1, (i > 0), $urandom);
        step(1, '0, 0, 1, $urandom);
        @(negedge clk);
        check("cnt_p1", gnt_cnt_o[1], CntEn ? 32'd5 : 32'd0);
        check("cnt_p0_p2", {gnt_cnt_o[0], gnt_cnt_o[2]}, '0);

        // Response with nothing outstanding
        step(1, '0, 0, 1, $urandom);
        @(negedge clk);
        check("orphan_rvalid", rvalid_o, '0);
        for (int i = 0; i < 3; i++) begin
            step(1, '0, 0, 0, '0);
            @(negedge clk);
            check("err_sticky", err_o, 1'b1);
        end
        step(0, '0, 0, 0, '0);
        step(1, '0, 0, 0, '0);
        @(negedge clk);
        check("err_cleared", err_o, 1'b0);

        // Reset mid-transaction discards routing
        step(1, 3'b001, 1, 0, '0);
        step(0, '0, 0, 0, '0);
        step(1, '0, 0, 1, $urandom);
        @(negedge clk);
        check("post_reset_rvalid", rvalid_o, '0);
        step(1, '0, 0, 0, '0);
        @(negedge clk);
        check("post_reset_err", err_o, 1'b1);
        step(0, '0, 0, 0, '0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic g;
            logic v;
            rq = NP'($urandom);
            if (m_locked && $urandom_range(0, 19) != 0) rq[m_lock_port] = 1'b1;
            g = 1'($urandom_range(0, 1));
            if (m_route.size() > 0) v = ($urandom_range(0, 2) == 0);
            else                    v = ($urandom_range(0, 199) == 0);
            step(1, rq, g, v, $urandom);
        end

        step(1, '0, 0, 0, '0);
        step(1, '0, 0, 0, '0);
        @(negedge clk);
        #1;
        check("gnt_queue_drained", gnt_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("cyc_queue_drained", cyc_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
